cla_accum_display: RTL and testbench
====================================

// Module: cla_accum_display
// PURPOSE
//  Registered, parametrised carry-lookahead adder/accumulator feeding a time-multiplexed
//  hex seven-segment display. Built from 4-bit lookahead groups; accepts operands by
//  valid/ready handshake. Optional accumulate mode adds A to a running total.
//  Sits between switch/bus inputs and the board's common-anode display.
// PARAMETERS
//  WIDTH        8   operand/sum width; multiple of 4; DIGITS = WIDTH/4 (localparam)
//  REFRESH_DIV  50000  clk cycles each digit stays lit; >= 1
// PORTS
//  clk        in   1       single system clock, rising edge
//  rst_n      in   1       synchronous, active-low reset
//  a          in   WIDTH   operand A
//  b          in   WIDTH   operand B (ignored in accumulate mode)
//  cin        in   1       carry in
//  mode       in   1       0 = sum = A + B + cin; 1 = sum = A + acc + cin, acc <= sum
//  clear      in   1       synchronous accumulator clear
//  in_valid   in   1       operands valid
//  in_ready   out  1       block can accept operands
//  sum        out  WIDTH   registered result; holds until next result
//  cout       out  1       carry out of MSB, registered with sum
//  ovf        out  1       signed overflow: (opA[msb]==opB[msb]) && (sum[msb]!=opA[msb])
//  out_valid  out  1       one-cycle pulse when sum/cout/ovf update
//  seg        out  7       {g,f,e,d,c,b,a}, active-low, registered
//  an         out  DIGITS  digit enables, active-low, one-hot-low, registered
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state IDLE; sum/cout/ovf/acc = 0; out_valid = 0;
//    in_ready = 0 while rst_n low; an = all ones; seg = 7'h7F; refresh cnt and digit idx = 0.
//  - FSM IDLE -> LOAD -> EXEC -> IDLE.
//    IDLE: in_ready=1. Accept when in_valid && in_ready: latch a, b (or acc), cin, mode.
//    LOAD: in_ready=0; CLA evaluated on latched operands.
//    EXEC: in_ready=0; sum/cout/ovf registered, out_valid=1 this cycle; acc <= sum if mode=1.
//  - Latency: out_valid asserts 2 cycles after accept edge; throughput 1 op / 3 cycles.
//  - in_valid while not IDLE is ignored (no queueing).
//  - clear: acc <= 0 at any state. clear coincident with an accumulate accept: operand is 0
//    (clear wins). clear coincident with EXEC accumulate writeback: acc <= 0 (clear wins);
//    sum still reports computed value.
//  - Arithmetic modulo 2^WIDTH; carry ripples only between 4-bit groups' G/P terms.
//  - Display: counter 0..REFRESH_DIV-1; on wrap, digit idx <= (idx==DIGITS-1)?0:idx+1.
//    an[idx]=0, others 1; seg = hex pattern of sum[4*idx+:4]; both registered, so update
//    one cycle after idx changes. Digit 0 lit starting 1 cycle after reset release.
//  - Display reads sum register only; no blanking during computation.
//  - Reset mid-operation: aborts; no out_valid pulse; acc cleared.
// STRUCTURE
//  - Package cla_disp_pkg: state enum {IDLE,LOAD,EXEC}; 16-entry hex->seg table
//    (active-low); blank pattern 7'h7F.
//  - Sub-module cla_group4: 4-bit sum, group generate/propagate; instantiated WIDTH/4 times
//    with top-level lookahead carry unit.
// TESTING (WIDTH=8, REFRESH_DIV=4)
//  1. rst_n=0 3 cycles -> sum=0, out_valid=0, in_ready=0, an=2'b11, seg=7'h7F; release -> in_ready=1.
//  2. mode0 a=8'h7F b=8'h01 cin0 -> 2 cycles later out_valid pulse, sum=8'h80, cout=0, ovf=1.
//  3. mode0 a=8'hFF b=8'h01 cin1 -> sum=8'h01, cout=1, ovf=0; in_ready low for 2 cycles.
//  4. clear, then mode1 a=8'h05 x3 -> sums 8'h05, 8'h0A, 8'h0F; clear+accept with a=8'h02 -> sum=8'h02.
//  5. sum=8'h3C -> an=2'b10 seg=7'b1000110 (C) for 4 cycles, then an=2'b01 seg=7'b0110000 (3), repeat.
//  6. in_valid held high during LOAD/EXEC -> single accept only; rst_n=0 in LOAD -> no out_valid, IDLE.

Source files
------------

// File: rtl/cla_disp_pkg.sv
// rtl/cla_disp_pkg.sv - shared types and display patterns for cla_accum_display
// Purpose: FSM state encoding, blank pattern and hex-to-segment lookup.
// Ports:   none (package).
package cla_disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EXEC = 2'd2
  } state_t;

  // Segment order {g,f,e,d,c,b,a}; a 0 lights the segment (common anode).
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = 7'h40;
      4'h1: pat = 7'h79;
      4'h2: pat = 7'h24;
      4'h3: pat = 7'h30;
      4'h4: pat = 7'h19;
      4'h5: pat = 7'h12;
      4'h6: pat = 7'h02;
      4'h7: pat = 7'h78;
      4'h8: pat = 7'h00;
      4'h9: pat = 7'h10;
      4'hA: pat = 7'h08;
      4'hB: pat = 7'h03;
      4'hC: pat = 7'h46;
      4'hD: pat = 7'h21;
      4'hE: pat = 7'h06;
      default: pat = 7'h0E;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/cla_group4.sv
// rtl/cla_group4.sv - 4-bit carry-lookahead group
// Purpose: 4-bit sum with internal lookahead plus group generate/propagate.
// Ports:   a, b (4-bit operands), cin (group carry in),
//          sum (4-bit result), gg (group generate), pg (group propagate).
module cla_group4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       gg,
  output logic       pg
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every internal carry is a flat sum of products of g/p and cin.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

  assign sum = p ^ c;

  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign pg = &p;

endmodule

// File: rtl/cla_accum_display.sv
// rtl/cla_accum_display.sv - registered CLA adder/accumulator with muxed hex display
// Purpose: accepts operands by valid/ready, computes A+B+cin (or A+acc+cin in
//          accumulate mode) through 4-bit lookahead groups, registers the result
//          and scans it onto a common-anode seven-segment display.
// Ports:   clk, rst_n (sync active-low); a, b, cin, mode, clear, in_valid, in_ready;
//          sum, cout, ovf, out_valid (result); seg, an (display, active-low).
module cla_accum_display
  import cla_disp_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 cin,
  input  logic                 mode,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     sum,
  output logic                 cout,
  output logic                 ovf,
  output logic                 out_valid,
  output logic [6:0]           seg,
  output logic [WIDTH/4-1:0]   an
);

  localparam int DIGITS = WIDTH / 4;
  localparam int CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic             op_mode;
  logic [WIDTH-1:0] acc;

  logic [WIDTH-1:0] cla_sum;
  logic [DIGITS:0]  carry;
  logic [DIGITS-1:0] grp_g;
  logic [DIGITS-1:0] grp_p;

  // Carries ripple between groups using only the group G/P terms.
  assign carry[0] = op_cin;

  for (genvar i = 0; i < DIGITS; i++) begin : g_grp
    cla_group4 u_grp (
      .a   (op_a[4*i +: 4]),
      .b   (op_b[4*i +: 4]),
      .cin (carry[i]),
      .sum (cla_sum[4*i +: 4]),
      .gg  (grp_g[i]),
      .pg  (grp_p[i])
    );
    assign carry[i+1] = grp_g[i] | (grp_p[i] & carry[i]);
  end

  // Gated by rst_n so the block never advertises readiness while held in reset.
  assign in_ready = rst_n && (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_a      <= '0;
      op_b      <= '0;
      op_cin    <= 1'b0;
      op_mode   <= 1'b0;
      acc       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            op_a    <= a;
            // A clear arriving with an accumulate accept zeroes the operand too.
            op_b    <= mode ? (clear ? '0 : acc) : b;
            op_cin  <= cin;
            op_mode <= mode;
            state   <= LOAD;
          end
        end
        LOAD: begin
          sum       <= cla_sum;
          cout      <= carry[DIGITS];
          ovf       <= (op_a[WIDTH-1] == op_b[WIDTH-1]) && (cla_sum[WIDTH-1] != op_a[WIDTH-1]);
          out_valid <= 1'b1;
          state     <= EXEC;
        end
        EXEC: state <= IDLE;
        default: state <= IDLE;
      endcase

      // Clear beats the accumulate writeback; sum still reports the computed value.
      if (clear) begin
        acc <= '0;
      end else if (state == LOAD && op_mode) begin
        acc <= cla_sum;
      end
    end
  end

  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
      an  <= '1;
      seg <= SEG_BLANK;
    end else begin
      if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
        cnt <= '0;
        idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      // Outputs follow idx by one cycle; the display always shows the sum register.
      an  <= ~(DIGITS'(1) << idx);
      seg <= hex_to_seg(sum[4*idx +: 4]);
    end
  end

endmodule

// File: tb/tb_cla_accum_display.sv
// tb/tb_cla_accum_display.sv - scoreboard bench for cla_accum_display
module tb_cla_accum_display;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       op_cin;
  logic       op_mode;
  logic       op_clear;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;
  logic       out_valid;
  logic [6:0] seg;
  logic [1:0] an;

  cla_accum_display #(.WIDTH(8), .REFRESH_DIV(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (op_a),
    .b         (op_b),
    .cin       (op_cin),
    .mode      (op_mode),
    .clear     (op_clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .out_valid (out_valid),
    .seg       (seg),
    .an        (an)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] s;
    logic       c;
    logic       o;
  } res_t;

  res_t       exp_q[$];
  int         tests = 0;
  int         fails = 0;
  int         pulses = 0;
  logic [7:0] macc = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      res_t e;
      pulses++;
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sum", 32'(sum), 32'(e.s));
        chk("cout", 32'(cout), 32'(e.c));
        chk("ovf", 32'(ovf), 32'(e.o));
      end
    end
  end

  function automatic res_t model(input logic [7:0] x, input logic [7:0] y, input logic ci);
    res_t r;
    logic [8:0] t;
    t   = {1'b0, x} + {1'b0, y} + {8'h00, ci};
    r.s = t[7:0];
    r.c = t[8];
    r.o = (x[7] == y[7]) && (t[7] != x[7]);
    return r;
  endfunction

  // One full transaction with latency/handshake checks; clr_wb drives clear
  // on the writeback edge.
  task automatic do_op(input logic [7:0] x, input logic [7:0] y, input logic ci,
                       input logic md, input logic clr, input logic clr_wb);
    res_t r;
    logic [7:0] yy;
    @(negedge clk);
    if (clr) macc = 8'h00;
    yy = md ? macc : y;
    r  = model(x, yy, ci);
    exp_q.push_back(r);
    if (md) macc = r.s;
    if (clr_wb) macc = 8'h00;
    op_a = x; op_b = y; op_cin = ci; op_mode = md; op_clear = clr; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; op_clear = clr_wb;
    chk("ready_load", 32'(in_ready), 32'd0);
    chk("ov_load", 32'(out_valid), 32'd0);
    @(negedge clk);
    op_clear = 1'b0;
    chk("ready_exec", 32'(in_ready), 32'd0);
    chk("ov_exec", 32'(out_valid), 32'd1);
    @(negedge clk);
    chk("ready_idle", 32'(in_ready), 32'd1);
    chk("ov_idle", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int   p0;
    logic found;
    logic [1:0] prev;

    rst_n = 1'b0; op_a = '0; op_b = '0; op_cin = 1'b0; op_mode = 1'b0;
    op_clear = 1'b0; in_valid = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_sum", 32'(sum), 32'h00);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_an", 32'(an), 32'h3);
    chk("rst_seg", 32'(seg), 32'h7F);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("rel_an", 32'(an), 32'h2);
    chk("rel_seg", 32'(seg), 32'h40);

    // Plain adds: signed overflow, then carry out with cin.
    do_op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op(8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    do_op(8'h80, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);

    // Accumulate sequence.
    @(negedge clk); op_clear = 1'b1;
    @(negedge clk); op_clear = 1'b0; macc = 8'h00;
    do_op(8'h05, 8'hAA, 1'b0, 1'b1, 1'b0, 1'b0);
    do_op(8'h05, 8'hAA, 1'b0, 1'b1, 1'b0, 1'b0);
    do_op(8'h05, 8'hAA, 1'b0, 1'b1, 1'b0, 1'b0);
    do_op(8'h02, 8'hAA, 1'b0, 1'b1, 1'b1, 1'b0);
    do_op(8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    do_op(8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

    // Display scan of 8'h3C.
    do_op(8'h3C, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    found = 1'b0;
    prev  = an;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (prev == 2'b01 && an == 2'b10) found = 1'b1;
      prev = an;
    end
    chk("disp_sync", 32'(found), 32'd1);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      chk("disp_an0", 32'(an), 32'h2);
      chk("disp_seg0", 32'(seg), 32'h46);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("disp_an1", 32'(an), 32'h1);
      chk("disp_seg1", 32'(seg), 32'h30);
    end
    @(negedge clk);
    chk("disp_an0_again", 32'(an), 32'h2);

    // in_valid held through LOAD/EXEC gives a single accept.
    @(negedge clk);
    p0 = pulses;
    exp_q.push_back(model(8'h10, 8'h20, 1'b0));
    op_a = 8'h10; op_b = 8'h20; op_cin = 1'b0; op_mode = 1'b0; in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("held_single_pulse", 32'(pulses - p0), 32'd1);

    // Reset while in LOAD aborts the operation and clears acc.
    do_op(8'h07, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    p0 = pulses;
    op_a = 8'h44; op_b = 8'h11; op_mode = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    macc = 8'h00;
    repeat (4) @(negedge clk);
    chk("rst_mid_no_pulse", 32'(pulses - p0), 32'd0);
    chk("rst_mid_ready", 32'(in_ready), 32'd1);
    do_op(8'h03, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
